// File: rtl/amp_seq_if.sv
// amp_seq_if: sample strobe, volume in, and amplifier control out.
// master drives the codec/pot side; slave is the sequencer.
interface amp_seq_if;
  logic        valid;
  logic [11:0] vol_pot;
  logic        amp_on;
  logic [11:0] vol_out;
  logic [1:0]  seq_state;

  modport master (
    output valid,
    output vol_pot,
    input  amp_on,
    input  vol_out,
    input  seq_state
  );

  modport slave (
    input  valid,
    input  vol_pot,
    output amp_on,
    output vol_out,
    output seq_state
  );
endinterface

// File: rtl/amp_seq.sv
// amp_seq: amplifier power-up sequencer (fill, soft ramp, run, watchdog).
// Soft ramp enabled by defining AMP_SOFT_RAMP_EN.
module amp_seq #(
  parameter int FILL_CNT  = 1536,
  parameter int RAMP_STEP = 4,
  parameter int TIMEOUT   = 4096
) (
  input logic      clk,
  input logic      rst_n,
  amp_seq_if.slave io
);

  localparam int CW = $clog2(FILL_CNT);
  localparam int WW = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0] CNT_LAST = CW'(FILL_CNT - 1);
  localparam logic [WW-1:0] WD_MAX   = WW'(TIMEOUT);
  localparam logic [WW-1:0] WD_PRE   = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RAMP = 2'd2,
    RUN  = 2'd3
  } state_t;

  state_t        state_q;
  logic          valid_q;
  logic [CW-1:0] cnt_q;
  logic [WW-1:0] wd_q;
  logic [WW-1:0] wd_d;
  logic          amp_on_q;
  logic [11:0]   vol_q;

  logic          rise;
  logic          wd_hit;
  logic          cnt_last;

  always_comb begin
    rise     = io.valid & ~valid_q;
    cnt_last = (cnt_q == CNT_LAST);
    // a rising edge on the expiring cycle keeps the stream alive
    wd_hit   = ~rise & (wd_q == WD_PRE);
    if (rise)
      wd_d = '0;
    else if (wd_q == WD_MAX)
      wd_d = wd_q;
    else
      wd_d = wd_q + WW'(1);
  end

`ifdef AMP_SOFT_RAMP_EN
  localparam logic [12:0] STEP = 13'(RAMP_STEP);

  logic [12:0] ramp_sum;
  logic [11:0] ramp_v;

  always_comb begin
    ramp_sum = {1'b0, vol_q} + STEP;
    if (ramp_sum > {1'b0, io.vol_pot})
      ramp_v = io.vol_pot;
    else
      ramp_v = ramp_sum[11:0];
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      valid_q  <= 1'b0;
      cnt_q    <= '0;
      wd_q     <= '0;
      amp_on_q <= 1'b0;
      vol_q    <= '0;
    end else begin
      valid_q <= io.valid;
      wd_q    <= wd_d;
      unique case (state_q)
        IDLE: begin
          state_q <= FILL;
        end
        FILL: begin
          if (wd_hit) begin
            cnt_q <= '0;
          end else if (rise) begin
            if (cnt_last) begin
              cnt_q    <= '0;
              amp_on_q <= 1'b1;
`ifdef AMP_SOFT_RAMP_EN
              state_q  <= RAMP;
`else
              state_q  <= RUN;
`endif
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        RAMP: begin
`ifdef AMP_SOFT_RAMP_EN
          if (wd_hit) begin
            state_q  <= FILL;
            cnt_q    <= '0;
            amp_on_q <= 1'b0;
            vol_q    <= '0;
          end else if (io.vol_pot < vol_q) begin
            vol_q   <= io.vol_pot;
            state_q <= RUN;
          end else if (rise) begin
            vol_q <= ramp_v;
            if (ramp_v == io.vol_pot)
              state_q <= RUN;
          end
`else
          state_q  <= FILL;
          cnt_q    <= '0;
          amp_on_q <= 1'b0;
          vol_q    <= '0;
`endif
        end
        RUN: begin
          if (wd_hit) begin
            state_q  <= FILL;
            cnt_q    <= '0;
            amp_on_q <= 1'b0;
            vol_q    <= '0;
          end else begin
            amp_on_q <= 1'b1;
            vol_q    <= io.vol_pot;
          end
        end
      endcase
    end
  end

  assign io.amp_on    = amp_on_q;
  assign io.vol_out   = vol_q;
  assign io.seq_state = state_q;

endmodule
